// File: rtl/usbfs_out_drain.sv
// usbfs_out_drain: drains OUT transactions for one USB full-speed endpoint.
// A qualifying OUT token arms the endpoint; the following DATA0/DATA1 packet
// is checked against the expected data toggle and against the free space in a
// {last,byte} FIFO of depth 2*MAX_PKT. The handshake (ACK/NAK) goes out the
// cycle after the DATA end-of-packet, and accepted payload bytes are copied
// from the receiver buffer into the FIFO, which is presented as a byte stream.
// Optional feature: define USBFS_OUT_DRAIN_TIMEOUT_EN to abandon an ARMED
// endpoint after TIMEOUT cycles without a DATA packet.
module usbfs_out_drain #(
  parameter int MAX_PKT = 8,
  parameter int ENDP    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                       i_clk_48MHz,
  input  logic                       i_rst,
  input  logic [6:0]                 i_devAddr,
  input  logic                       i_toggleClr,
  input  logic                       i_eop,
  input  logic [3:0]                 i_pid,
  input  logic [6:0]                 i_addr,
  input  logic [3:0]                 i_endp,
  input  logic                       i_pidOkay,
  input  logic                       i_tokenOkay,
  input  logic                       i_dataOkay,
  output logic                       o_rdEn,
  output logic [$clog2(MAX_PKT)-1:0] o_rdIdx,
  input  logic [7:0]                 i_rdByte,
  input  logic [$clog2(MAX_PKT):0]   i_rdNBytes,
  output logic                       o_ack,
  output logic                       o_nak,
  output logic                       o_valid,
  output logic [7:0]                 o_data,
  output logic                       o_last,
  input  logic                       i_ready
);

  localparam int IW    = $clog2(MAX_PKT);     // read index width
  localparam int NW    = IW + 1;              // payload byte count width
  localparam int DEPTH = 2 * MAX_PKT;         // FIFO entries
  localparam int PW    = $clog2(DEPTH);       // FIFO pointer width
  localparam int CW    = PW + 1;              // FIFO occupancy width

  localparam logic [3:0]    PID_OUT   = 4'b0001;
  localparam logic [3:0]    PID_DATA0 = 4'b0011;
  localparam logic [3:0]    PID_DATA1 = 4'b1011;
  localparam logic [3:0]    ENDP_L    = 4'(ENDP);
  localparam logic [CW-1:0] DEPTH_L   = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_COPY  = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic           toggle_q, toggle_d;       // expected data toggle (0 = DATA0)
  logic           ack_q, ack_d;
  logic           nak_q, nak_d;
  logic           rd_en_q, rd_en_d;
  logic [IW-1:0]  rd_idx_q, rd_idx_d;
  logic [NW-1:0]  n_q, n_d;                 // byte count of the packet being copied
  logic           pend_q, pend_d;           // i_rdByte carries a byte to push
  logic           pend_last_q, pend_last_d; // that byte is the packet's last

  // FIFO storage and bookkeeping
  logic [8:0]     mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [8:0]     head_s;
  logic           push_s, pop_s;
  logic [CW-1:0]  free_s;

  // Packet qualification
  logic           tok_ok_s;
  logic           data_ok_s;
  logic           fits_s;
  logic [NW-1:0]  n_m1_s;
  logic           last_rd_s;

`ifdef USBFS_OUT_DRAIN_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]  tmo_q, tmo_d;
`endif

  assign tok_ok_s  = i_eop && i_pidOkay && i_tokenOkay && (i_pid == PID_OUT) &&
                     (i_addr == i_devAddr) && (i_endp == ENDP_L);
  assign data_ok_s = i_pidOkay && i_dataOkay &&
                     ((i_pid == PID_DATA0) || (i_pid == PID_DATA1));
  assign free_s    = DEPTH_L - cnt_q;
  assign fits_s    = ({1'b0, i_rdNBytes} <= free_s);
  assign n_m1_s    = n_q - {{(NW-1){1'b0}}, 1'b1};
  // A malformed count beyond the buffer size still ends at the last buffer entry.
  assign last_rd_s = ({1'b0, rd_idx_q} == n_m1_s) || (rd_idx_q == {IW{1'b1}});

  assign push_s    = pend_q;
  assign pop_s     = (cnt_q != {CW{1'b0}}) && i_ready;
  assign head_s    = mem_q[rd_ptr_q];

  // Stream outputs follow the FIFO head; forced to zero whenever it is empty.
  assign o_valid = (cnt_q != {CW{1'b0}});
  assign o_data  = o_valid ? head_s[7:0] : 8'h00;
  assign o_last  = o_valid ? head_s[8] : 1'b0;

  assign o_ack   = ack_q;
  assign o_nak   = nak_q;
  assign o_rdEn  = rd_en_q;
  assign o_rdIdx = rd_idx_q;

  // Control state registers.
  always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      toggle_q    <= 1'b0;
      ack_q       <= 1'b0;
      nak_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= {IW{1'b0}};
      n_q         <= {NW{1'b0}};
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
`ifdef USBFS_OUT_DRAIN_TIMEOUT_EN
      tmo_q       <= {TW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      toggle_q    <= toggle_d;
      ack_q       <= ack_d;
      nak_q       <= nak_d;
      rd_en_q     <= rd_en_d;
      rd_idx_q    <= rd_idx_d;
      n_q         <= n_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
`ifdef USBFS_OUT_DRAIN_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state, handshake and copy-sequencing logic.
  always_comb begin
    state_d     = state_q;
    toggle_d    = toggle_q;
    ack_d       = 1'b0;
    nak_d       = 1'b0;
    rd_en_d     = 1'b0;
    rd_idx_d    = {IW{1'b0}};
    n_d         = n_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
`ifdef USBFS_OUT_DRAIN_TIMEOUT_EN
    tmo_d       = {TW{1'b0}};
`endif
    case (state_q)
      ST_IDLE: begin
        if (tok_ok_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (i_eop) begin
          // Any end-of-packet leaves ARMED; only a clean DATA packet answers.
          state_d = ST_IDLE;
          if (data_ok_s) begin
            if (i_pid[3] != toggle_q) begin
              // Retransmission of a packet already taken: acknowledge, drop.
              ack_d = 1'b1;
            end else if (i_rdNBytes == {NW{1'b0}}) begin
              ack_d    = 1'b1;
              toggle_d = ~toggle_q;
            end else if (!fits_s) begin
              nak_d = 1'b1;
            end else begin
              ack_d    = 1'b1;
              toggle_d = ~toggle_q;
              state_d  = ST_COPY;
              rd_en_d  = 1'b1;
              n_d      = i_rdNBytes;
            end
          end else begin
            ack_d = 1'b0;
          end
        end else begin
`ifdef USBFS_OUT_DRAIN_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ARMED;
            tmo_d   = tmo_q + {{(TW-1){1'b0}}, 1'b1};
          end
`else
          state_d = ST_ARMED;
`endif
        end
      end
      ST_COPY: begin
        // Reads are issued back to back; each byte returns one cycle later.
        if (rd_en_q) begin
          pend_d = 1'b1;
          if (last_rd_s) begin
            pend_last_d = 1'b1;
          end else begin
            rd_en_d  = 1'b1;
            rd_idx_d = rd_idx_q + {{(IW-1){1'b0}}, 1'b1};
          end
        end else begin
          pend_d = 1'b0;
        end
        if (pend_q && pend_last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COPY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A host-requested toggle reset wins over a flip in the same cycle.
    if (i_toggleClr) begin
      toggle_d = 1'b0;
    end else begin
      toggle_d = toggle_d;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage write port; contents are don't-care while the entry is free.
  always_ff @(posedge i_clk_48MHz) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {pend_last_q, i_rdByte};
    end
  end

endmodule

// File: doc/usbfs_out_drain.md
USBFS_OUT_DRAIN -- requirements
Module: usbfs_out_drain

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8: wMaxPacketSize in {8,16,32,64}.
REQ-002 SHALL have parameter ENDP, default 1: endpoint number served.
REQ-003 SHALL have parameter TIMEOUT, default 1024: ARMED timeout in 48MHz cycles.
REQ-004 SHALL use one clock and an asynchronous, active-high reset (ports below).
REQ-005 i_clk_48MHz  in  1  sole clock.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_devAddr  in  7  assigned device address.
REQ-008 i_toggleClr  in  1  pulse; forces expected toggle to DATA0.
REQ-009 i_eop, i_pid, i_addr, i_endp  in  1/4/7/4  packet-receiver end-of-packet pulse and last PID/ADDR/ENDP.
REQ-010 i_pidOkay, i_tokenOkay, i_dataOkay  in  1 each  receiver integrity flags, valid at i_eop.
REQ-011 o_rdEn, o_rdIdx  out  1, clog2(MAX_PKT)  receiver buffer read request.
REQ-012 i_rdByte, i_rdNBytes  in  8, clog2(MAX_PKT)+1  read data (cycle after o_rdEn), payload byte count.
REQ-013 o_ack, o_nak  out  1 each  single-cycle handshake requests to the transmitter.
REQ-014 o_valid, o_data, o_last  out  1/8/1  byte stream; o_last marks the packet's final byte.
REQ-015 i_ready  in  1  stream sink ready.

Function
REQ-016 SHALL contain a 9-bit-wide FIFO ({last,byte}) of depth 2*MAX_PKT; o_valid = not empty; pop on o_valid && i_ready.
REQ-017 States IDLE, ARMED, COPY.
REQ-018 IDLE->ARMED on i_eop with pid==OUT(4'b0001), pidOkay, tokenOkay, addr==i_devAddr, endp==ENDP; otherwise stay.
REQ-019 ARMED, i_eop with pid DATA0(4'b0011)/DATA1(4'b1011), pidOkay, dataOkay: evaluate, per REQ-020..023, on that cycle.
REQ-020 Toggle mismatch (duplicate): o_ack next cycle, no copy, toggle unchanged, ->IDLE.
REQ-021 Match, nBytes==0: o_ack next cycle, toggle flips, ->IDLE.
REQ-022 Match, nBytes>FIFO free space: o_nak next cycle, toggle unchanged, ->IDLE.
REQ-023 Match, room: o_ack next cycle, toggle flips, ->COPY.
REQ-024 ARMED, any other i_eop (bad flags or non-DATA PID): no handshake, ->IDLE.
REQ-025 COPY: o_rdEn=1 with o_rdIdx 0..nBytes-1 on consecutive cycles; each i_rdByte pushed one cycle later, last flagged; ->IDLE after final push (nBytes+1 cycles).
REQ-026 i_eop during COPY SHALL be ignored.
REQ-027 Push and pop in same cycle SHALL both occur; free space counted from FIFO occupancy before copy.
REQ-028 i_toggleClr SHALL take priority over a same-cycle toggle flip.
REQ-029 o_ack and o_nak never simultaneously high.

Reset
REQ-030 i_rst SHALL immediately force state IDLE, FIFO empty, toggle DATA0, o_rdEn/o_rdIdx/o_ack/o_nak/o_valid/o_last/o_data=0, timeout counter 0; reset mid-COPY discards the partial packet.

Configuration
REQ-031 Macro USBFS_OUT_DRAIN_TIMEOUT_EN defined: counter counts ARMED cycles; on reaching TIMEOUT-1 without a qualifying i_eop ->IDLE, no handshake.
REQ-032 Macro undefined: no counter; ARMED persists until next i_eop.

Verification
REQ-033 devAddr=5, OUT addr5 endp1, DATA0 bytes 11,22,33, ready=1 -> o_ack 1 cycle after eop; stream 11,22,33, o_last on 33; toggle=DATA1.
REQ-034 Then OUT + DATA0 repeat -> o_ack, no stream bytes, toggle stays DATA1.
REQ-035 OUT + DATA1 with dataOkay=0 -> no o_ack/o_nak, state IDLE, toggle unchanged.
REQ-036 MAX_PKT=8, ready=0, two 8-byte accepted packets then 1-byte packet -> third gets o_nak, FIFO holds 16 bytes.
REQ-037 TIMEOUT_EN, OUT then 1024 idle cycles, then DATA0 -> no handshake, no bytes.
REQ-038 i_rst asserted mid-COPY -> all outputs 0 same cycle, FIFO empty after release.
